cu_pepo_ctrl: RTL and testbench



---
 rtl/cu_pepo_pkg.sv | 87 ++++++++
 rtl/cu_pepo_encoder.sv | 26 ++
 rtl/cu_pepo_ctrl.sv | 109 ++++++++++
 tb/tb_cu_pepo_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cu_pepo_pkg.sv
// cu_pepo_pkg: shared types, state numbers, control-register layout and datapath words for cu_pepo_ctrl.
package cu_pepo_pkg;
    typedef enum logic [2:0] {
        N_ENC, N_TGT, N_INC, N_CTGT, N_CENC, N_WAIT, N_FETCH, N_HOLD
    } nsel_e;
    typedef enum logic [1:0] {S_COND, S_MOC, S_LEND, S_LDET} ssel_e;

    localparam logic [5:0] ST_IDLE    = 6'd0;
    localparam logic [5:0] ST_FETCH   = 6'd1;
    localparam logic [5:0] ST_READ    = 6'd2;
    localparam logic [5:0] ST_IR      = 6'd3;
    localparam logic [5:0] ST_DECODE  = 6'd4;
    localparam logic [5:0] ST_DP_IMM  = 6'd10;
    localparam logic [5:0] ST_DP_REG  = 6'd11;
    localparam logic [5:0] ST_LDR_IMM = 6'd20;
    localparam logic [5:0] ST_STR_IMM = 6'd24;
    localparam logic [5:0] ST_LDR_REG = 6'd28;
    localparam logic [5:0] ST_STR_REG = 6'd32;
    localparam logic [5:0] ST_LDM     = 6'd40;
    localparam logic [5:0] ST_STM     = 6'd48;
    localparam logic [5:0] ST_B       = 6'd56;
    localparam logic [5:0] ST_BL      = 6'd58;

    localparam int CTL_TGT_LO = 0;
    localparam int CTL_N_LO   = 8;
    localparam int CTL_INV    = 11;
    localparam int CTL_S_LO   = 12;
    localparam int CTL_OWN_LO = 24;
    localparam int CTL_DP_LO  = 30;

    // One-hot datapath strobes; the datapath decodes each bit independently
    localparam logic [34:0] DP_MAR_LD   = 35'h00001;
    localparam logic [34:0] DP_MDR_LD   = 35'h00002;
    localparam logic [34:0] DP_IR_LD    = 35'h00004;
    localparam logic [34:0] DP_PC_LD    = 35'h00008;
    localparam logic [34:0] DP_RF_LD    = 35'h00010;
    localparam logic [34:0] DP_MEM_EN   = 35'h00020;
    localparam logic [34:0] DP_MEM_RD   = 35'h00040;
    localparam logic [34:0] DP_ALU_ADD  = 35'h00080;
    localparam logic [34:0] DP_ALU_DP   = 35'h00100;
    localparam logic [34:0] DP_A_PC     = 35'h00200;
    localparam logic [34:0] DP_B_IMM    = 35'h00400;
    localparam logic [34:0] DP_B_4      = 35'h00800;
    localparam logic [34:0] DP_RD_MDR   = 35'h01000;
    localparam logic [34:0] DP_RD_LR    = 35'h02000;
    localparam logic [34:0] DP_MDR_RF   = 35'h04000;
    localparam logic [34:0] DP_FLAGS    = 35'h08000;
    localparam logic [34:0] DP_LSM_NEXT = 35'h10000;
    localparam logic [34:0] DP_MAR_INC  = 35'h20000;

    localparam logic [34:0] CW_NONE      = 35'h0;
    localparam logic [34:0] CW_MAR_PC    = DP_MAR_LD | DP_A_PC;
    localparam logic [34:0] CW_READ_PC4  = DP_MEM_EN | DP_MEM_RD | DP_PC_LD | DP_A_PC | DP_B_4 | DP_ALU_ADD;
    localparam logic [34:0] CW_IR_LOAD   = DP_MEM_EN | DP_MEM_RD | DP_MDR_LD | DP_IR_LD;
    localparam logic [34:0] CW_ALU_IMM   = DP_RF_LD | DP_ALU_DP | DP_B_IMM | DP_FLAGS;
    localparam logic [34:0] CW_ALU_REG   = DP_RF_LD | DP_ALU_DP | DP_FLAGS;
    localparam logic [34:0] CW_EA_IMM    = DP_MAR_LD | DP_ALU_ADD | DP_B_IMM;
    localparam logic [34:0] CW_EA_REG    = DP_MAR_LD | DP_ALU_ADD;
    localparam logic [34:0] CW_MEM_RD    = DP_MEM_EN | DP_MEM_RD;
    localparam logic [34:0] CW_MDR_WAIT  = DP_MEM_EN | DP_MEM_RD | DP_MDR_LD;
    localparam logic [34:0] CW_LD_RD     = DP_RF_LD | DP_RD_MDR;
    localparam logic [34:0] CW_ST_MDR    = DP_MDR_LD | DP_MDR_RF;
    localparam logic [34:0] CW_MEM_WR    = DP_MEM_EN;
    localparam logic [34:0] CW_LSM_NEXT  = DP_LSM_NEXT;
    localparam logic [34:0] CW_MAR_INC   = DP_MAR_INC;
    localparam logic [34:0] CW_WB        = DP_RF_LD | DP_ALU_ADD;
    localparam logic [34:0] CW_BRANCH    = DP_PC_LD | DP_A_PC | DP_B_IMM | DP_ALU_ADD;
    localparam logic [34:0] CW_LINK      = DP_RF_LD | DP_RD_LR | DP_A_PC;

    typedef struct packed {
        logic [34:0] dp;
        logic [5:0]  own;
        logic [9:0]  pad_hi;
        ssel_e       s;
        logic        inv;
        nsel_e       n;
        logic [1:0]  pad_lo;
        logic [5:0]  tgt;
    } uword_t;

    function automatic logic [64:0] uw(logic [5:0] own, nsel_e n, logic [34:0] dp,
                                       logic [5:0] tgt = ST_IDLE, ssel_e s = S_COND, logic inv = 1'b0);
        uword_t u;
        u = '{dp: dp, own: own, pad_hi: '0, s: s, inv: inv, n: n, pad_lo: '0, tgt: tgt};
        return u;
    endfunction
endpackage

// File: rtl/cu_pepo_encoder.sv
// cu_pepo_encoder: combinational IR to execute-state decoder; LSM decoding enabled by CU_LSM_EN.
module cu_pepo_encoder
    import cu_pepo_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [5:0]  o_state
);
    logic [2:0] w_op;
    logic       w_l;
    logic [5:0] w_lsm;
    logic       w_unused;
    assign w_op = i_ir[27:25];
    assign w_l  = i_ir[20];
`ifdef CU_LSM_EN
    assign w_lsm = w_l ? ST_LDM : ST_STM;
`else
    assign w_lsm = ST_FETCH;
`endif
    assign o_state = w_op == 3'b001               ? ST_DP_IMM :
                     (w_op == 3'b000 && !i_ir[4]) ? ST_DP_REG :
                     w_op == 3'b010               ? (w_l ? ST_LDR_IMM : ST_STR_IMM) :
                     w_op == 3'b011               ? (w_l ? ST_LDR_REG : ST_STR_REG) :
                     w_op == 3'b100               ? w_lsm :
                     w_op == 3'b101               ? (i_ir[24] ? ST_BL : ST_B) : ST_FETCH;
    assign w_unused = ^{i_ir[31:28], i_ir[23:21], i_ir[19:5], i_ir[3:0]};
endmodule

// File: rtl/cu_pepo_ctrl.sv
// cu_pepo_ctrl: microprogrammed control unit with a 64-entry ROM and one microstate per clock.
// CU_LSM_EN enables LDM/STM microcode, LSM decoding and the LSM_END/LSM_DETECT conditions.
module cu_pepo_ctrl
    import cu_pepo_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IR_OUT,
    input  logic        MOC,
    input  logic        COND,
    input  logic        LSM_DETECT,
    input  logic        LSM_END,
    output logic [34:0] cu_datapath
);
    logic [64:0] CTL_REG_CUI;
    logic [5:0]  w_state, w_tgt, w_inc, w_enc, w_next;
    nsel_e       w_n;
    ssel_e       w_s;
    logic        w_sel, w_c, w_unused;

    function automatic logic [64:0] rom_word(input logic [5:0] a);
        logic [64:0] w;
        w = uw(ST_IDLE, N_TGT, CW_NONE, ST_FETCH);
        case (a)
            ST_FETCH:          w = uw(a, N_INC, CW_MAR_PC);
            ST_READ:           w = uw(a, N_INC, CW_READ_PC4);
            ST_IR:             w = uw(a, N_WAIT, CW_IR_LOAD, ST_IDLE, S_MOC);
            ST_DECODE:         w = uw(a, N_CENC, CW_NONE, ST_FETCH, S_COND, 1'b1);
            ST_DP_IMM:         w = uw(a, N_FETCH, CW_ALU_IMM);
            ST_DP_REG:         w = uw(a, N_FETCH, CW_ALU_REG);
            ST_LDR_IMM:        w = uw(a, N_INC, CW_EA_IMM);
            ST_LDR_REG:        w = uw(a, N_INC, CW_EA_REG);
            ST_LDR_IMM + 6'd1,
            ST_LDR_REG + 6'd1: w = uw(a, N_INC, CW_MEM_RD);
            ST_LDR_IMM + 6'd2,
            ST_LDR_REG + 6'd2: w = uw(a, N_WAIT, CW_MDR_WAIT, ST_IDLE, S_MOC);
            ST_LDR_IMM + 6'd3,
            ST_LDR_REG + 6'd3: w = uw(a, N_FETCH, CW_LD_RD);
            ST_STR_IMM:        w = uw(a, N_INC, CW_EA_IMM);
            ST_STR_REG:        w = uw(a, N_INC, CW_EA_REG);
            ST_STR_IMM + 6'd1,
            ST_STR_REG + 6'd1: w = uw(a, N_INC, CW_ST_MDR);
            ST_STR_IMM + 6'd2,
            ST_STR_REG + 6'd2: w = uw(a, N_WAIT, CW_MEM_WR, ST_IDLE, S_MOC);
            ST_STR_IMM + 6'd3,
            ST_STR_REG + 6'd3: w = uw(a, N_FETCH, CW_NONE);
`ifdef CU_LSM_EN
            // Loop: +1 exit on list end, +2 skip clear bits, memory access, +6 advance list
            ST_LDM:            w = uw(a, N_INC, CW_EA_REG);
            ST_LDM + 6'd1:     w = uw(a, N_CTGT, CW_NONE, ST_LDM + 6'd7, S_LEND);
            ST_LDM + 6'd2:     w = uw(a, N_CTGT, CW_NONE, ST_LDM + 6'd6, S_LDET, 1'b1);
            ST_LDM + 6'd3:     w = uw(a, N_INC, CW_MEM_RD);
            ST_LDM + 6'd4:     w = uw(a, N_WAIT, CW_MDR_WAIT, ST_IDLE, S_MOC);
            ST_LDM + 6'd5:     w = uw(a, N_INC, CW_LD_RD | CW_MAR_INC);
            ST_LDM + 6'd6:     w = uw(a, N_TGT, CW_LSM_NEXT, ST_LDM + 6'd1);
            ST_LDM + 6'd7:     w = uw(a, N_FETCH, CW_WB);
            ST_STM:            w = uw(a, N_INC, CW_EA_REG);
            ST_STM + 6'd1:     w = uw(a, N_CTGT, CW_NONE, ST_STM + 6'd7, S_LEND);
            ST_STM + 6'd2:     w = uw(a, N_CTGT, CW_NONE, ST_STM + 6'd6, S_LDET, 1'b1);
            ST_STM + 6'd3:     w = uw(a, N_INC, CW_ST_MDR);
            ST_STM + 6'd4:     w = uw(a, N_WAIT, CW_MEM_WR, ST_IDLE, S_MOC);
            ST_STM + 6'd5:     w = uw(a, N_INC, CW_MAR_INC);
            ST_STM + 6'd6:     w = uw(a, N_TGT, CW_LSM_NEXT, ST_STM + 6'd1);
            ST_STM + 6'd7:     w = uw(a, N_FETCH, CW_WB);
`endif
            ST_B:              w = uw(a, N_FETCH, CW_BRANCH);
            ST_BL:             w = uw(a, N_INC, CW_LINK);
            ST_BL + 6'd1:      w = uw(a, N_FETCH, CW_BRANCH);
            default:           w = uw(ST_IDLE, N_TGT, CW_NONE, ST_FETCH);
        endcase
        return w;
    endfunction

    cu_pepo_encoder u_enc (.i_ir(IR_OUT), .o_state(w_enc));

    assign w_state = CTL_REG_CUI[CTL_OWN_LO +: 6];
    assign w_tgt   = CTL_REG_CUI[CTL_TGT_LO +: 6];
    assign w_inc   = w_state + 6'd1;
    assign w_n     = nsel_e'(CTL_REG_CUI[CTL_N_LO +: 3]);
    assign w_s     = ssel_e'(CTL_REG_CUI[CTL_S_LO +: 2]);
`ifdef CU_LSM_EN
    assign w_sel = w_s == S_COND ? COND : w_s == S_MOC ? MOC : w_s == S_LEND ? LSM_END : LSM_DETECT;
`else
    assign w_sel = w_s == S_COND ? COND : w_s == S_MOC ? MOC : 1'b0;
`endif
    assign w_c      = w_sel ^ CTL_REG_CUI[CTL_INV];
    assign w_unused = ^{LSM_END, LSM_DETECT, CTL_REG_CUI[7:6], CTL_REG_CUI[23:14]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) CTL_REG_CUI <= rom_word(ST_IDLE);
        else       CTL_REG_CUI <= rom_word(w_next);
    end

    always_comb begin
        w_next = w_state;
        case (w_n)
            N_ENC:   w_next = w_enc;
            N_TGT:   w_next = w_tgt;
            N_INC:   w_next = w_inc;
            N_CTGT:  w_next = w_c ? w_tgt : w_inc;
            N_CENC:  w_next = w_c ? w_tgt : w_enc;
            N_WAIT:  w_next = w_c ? w_inc : w_state;
            N_FETCH: w_next = ST_FETCH;
            default: w_next = w_state;
        endcase
    end

    always_comb cu_datapath = CTL_REG_CUI[CTL_DP_LO +: 35];
endmodule

// File: tb/tb_cu_pepo_ctrl.sv
// tb_cu_pepo_ctrl: scoreboard bench for cu_pepo_ctrl microstate sequencing; honours CU_LSM_EN.
module tb_cu_pepo_ctrl;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IR_OUT = 32'h0;
    logic        MOC = 1'b0, COND = 1'b0, LSM_DETECT = 1'b0, LSM_END = 1'b0;
    logic [34:0] cu_datapath;
    logic [5:0]  st;
    logic [5:0]  sb[$];
    int          checks = 0, passed = 0;

    localparam logic [31:0] IR_ADD  = 32'hE2811001;
    localparam logic [31:0] IR_ADDR = 32'hE0810002;
    localparam logic [31:0] IR_MUL  = 32'hE0000090;
    localparam logic [31:0] IR_LDR  = 32'hE5912000;
    localparam logic [31:0] IR_STR  = 32'hE5812000;
    localparam logic [31:0] IR_LDRR = 32'hE7912003;
    localparam logic [31:0] IR_B    = 32'hEA000002;
    localparam logic [31:0] IR_BL   = 32'hEB000002;
    localparam logic [31:0] IR_LDM  = 32'hE8900006;

    typedef struct packed {
        logic        moc, cond, lend, ldet;
        logic [31:0] ir;
        logic [5:0]  nxt;
    } step_t;

    cu_pepo_ctrl dut (
        .CLK(CLK), .RESET(RESET), .IR_OUT(IR_OUT), .MOC(MOC), .COND(COND),
        .LSM_DETECT(LSM_DETECT), .LSM_END(LSM_END), .cu_datapath(cu_datapath)
    );

    always #5 CLK = ~CLK;
    assign st = dut.CTL_REG_CUI[29:24];

    function automatic step_t stp(logic moc, logic cond, logic lend, logic ldet, logic [31:0] ir, logic [5:0] nxt);
        return '{moc: moc, cond: cond, lend: lend, ldet: ldet, ir: ir, nxt: nxt};
    endfunction

    function automatic step_t fx(logic [5:0] nxt);
        return stp(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, nxt);
    endfunction

    // Applies one cycle of inputs, records the state the spec requires after the edge
    task automatic drive(input step_t t);
        MOC = t.moc; COND = t.cond; LSM_END = t.lend; LSM_DETECT = t.ldet; IR_OUT = t.ir;
        sb.push_back(t.nxt);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        logic [5:0] e;
        RESET = 1'b1;
        #2;
        checks++;
        if (cu_datapath !== 35'd0) $display("FAIL reset_dp got=%h want=0", cu_datapath); else passed++;
        checks++;
        if (st !== 6'd0) $display("FAIL reset_state got=%0d want=0", st); else passed++;
        #4 RESET = 1'b0;
        sb.push_back(6'd1);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        checks++;
        if (st !== e) $display("FAIL reset_release got=%0d want=%0d", st, e); else passed++;
    endtask

    task automatic test_fetch;
        step_t t[$];
        logic [5:0] e;
        t = {stp(0,0,0,0,IR_ADD,2), stp(0,0,0,0,IR_ADD,3), stp(0,0,0,0,IR_ADD,3),
             stp(0,0,0,0,IR_ADD,3), stp(0,0,0,0,IR_ADD,3), stp(1,0,0,0,IR_ADD,4)};
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (st !== e) $display("FAIL fetch[%0d] got=%0d want=%0d", i, st, e); else passed++;
        end
    endtask

    task automatic test_cond_fail;
        step_t t[$];
        logic [5:0] e;
        t = {stp(0,0,0,0,IR_ADD,1), fx(2), fx(3), fx(4),
             stp(0,0,0,0,IR_B,1), fx(2), fx(3), fx(4),
             stp(0,0,1,1,IR_LDR,1), fx(2), fx(3), fx(4)};
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (st !== e) $display("FAIL cond_fail[%0d] got=%0d want=%0d", i, st, e); else passed++;
        end
    endtask

    task automatic test_decode;
        step_t t[$];
        logic [5:0] e;
        t = {stp(0,1,0,0,IR_ADD,10), fx(1), fx(2), fx(3), fx(4),
             stp(0,1,0,0,IR_ADDR,11), fx(1), fx(2), fx(3), fx(4),
             stp(0,1,0,0,IR_MUL,1), fx(2), fx(3), fx(4),
             stp(0,1,0,0,IR_LDR,20), fx(21), fx(22), stp(0,0,0,0,0,22), fx(23), fx(1), fx(2), fx(3), fx(4),
             stp(0,1,0,0,IR_STR,24), fx(25), fx(26), stp(0,0,0,0,0,26), fx(27), fx(1), fx(2), fx(3), fx(4),
             stp(0,1,0,0,IR_LDRR,28), fx(29), fx(30), fx(31), fx(1), fx(2), fx(3), fx(4),
             stp(0,1,0,0,IR_B,56), fx(1), fx(2), fx(3), fx(4),
             stp(0,1,0,0,IR_BL,58), fx(59), fx(1), fx(2), fx(3), fx(4)};
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (st !== e) $display("FAIL decode[%0d] got=%0d want=%0d", i, st, e); else passed++;
        end
    endtask

    task automatic test_lsm;
        step_t t[$];
        logic [5:0] e;
`ifdef CU_LSM_EN
        t = {stp(0,1,0,0,IR_LDM,40), stp(0,0,0,0,0,41), stp(0,0,0,0,0,42), stp(0,0,0,1,0,43),
             stp(0,0,0,0,0,44), stp(0,0,0,0,0,44), stp(1,0,0,0,0,45), stp(0,0,0,0,0,46),
             stp(0,0,0,0,0,41), stp(0,0,0,0,0,42), stp(0,0,0,0,0,46), stp(0,0,0,0,0,41),
             stp(0,0,1,0,0,47), stp(0,0,0,0,0,1)};
`else
        t = {stp(0,1,0,0,IR_LDM,1)};
`endif
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (st !== e) $display("FAIL lsm[%0d] got=%0d want=%0d", i, st, e); else passed++;
        end
    endtask

    task automatic test_reset_mid;
        step_t t[$];
        logic [5:0] e;
        t = {fx(2), fx(3), fx(4), stp(0,1,0,0,IR_LDR,20), fx(21), fx(22), stp(0,0,0,0,0,22)};
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (st !== e) $display("FAIL mid_seq[%0d] got=%0d want=%0d", i, st, e); else passed++;
        end
        checks++;
        if (cu_datapath === 35'd0) $display("FAIL mid_dp_active got=%h want=nonzero", cu_datapath); else passed++;
        #3 RESET = 1'b1;
        #1;
        checks++;
        if (st !== 6'd0) $display("FAIL mid_reset_state got=%0d want=0", st); else passed++;
        checks++;
        if (cu_datapath !== 35'd0) $display("FAIL mid_reset_dp got=%h want=0", cu_datapath); else passed++;
        #2 RESET = 1'b0;
        sb.push_back(6'd1);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        checks++;
        if (st !== e) $display("FAIL mid_release got=%0d want=%0d", st, e); else passed++;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_cond_fail;
        test_decode;
        test_lsm;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
